reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of the shared storage register.
REQ-002 Port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: i_req  input  2  per-requester write request, bit k = requester k.
REQ-005 Port: i_d0  input  WIDTH  write data of requester 0.
REQ-006 Port: i_d1  input  WIDTH  write data of requester 1.
REQ-007 Port: o_gnt  output  2  one-hot grant to the requester currently being served.
REQ-008 Port: o_ack  output  2  one-cycle write-complete pulse to the served requester.
REQ-009 Port: o_q  output  WIDTH  shared register contents.
REQ-010 Port: o_qn  output  WIDTH  bitwise inverse of o_q.
REQ-011 Port: o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 States SHALL be IDLE, WRITE and ACK; encoding is left to the implementation.
REQ-013 IDLE: with any i_req bit high at edge N, the state SHALL become WRITE at edge N with o_gnt one-hot on the winner; with no request, it SHALL stay IDLE.
REQ-014 WRITE: if the granted i_req is still high at edge N+1, o_q SHALL load that requester's data, the state SHALL become ACK, o_ack[winner] SHALL be high and o_gnt SHALL be held.
REQ-015 WRITE abort: if the granted i_req is low at edge N+1, the state SHALL return to IDLE, o_q SHALL be unchanged and no o_ack SHALL be issued.
REQ-016 ACK: the state SHALL always return to IDLE at the next edge, clearing o_ack and o_gnt; o_ack is therefore high for exactly one cycle.
REQ-017 At least one IDLE cycle SHALL separate transactions; a request held high after its ack SHALL be treated as a new request.
REQ-018 Request-to-o_q-update latency SHALL be 2 edges; a back-to-back transaction occupies 3 cycles.
REQ-019 The non-granted requester SHALL see o_gnt and o_ack low, and its request SHALL have no effect until the state returns to IDLE.
REQ-020 A single requester SHALL always win irrespective of arbitration mode.
REQ-021 o_qn SHALL equal ~o_q in every cycle, including during reset.
REQ-022 Data on i_d0/i_d1 SHALL be sampled only at the WRITE-to-ACK edge.

Reset
REQ-023 When i_rst_n is low at an edge, the block SHALL set: state IDLE, o_q all zeros, o_qn all ones, o_gnt 0, o_ack 0, o_busy 0, last-winner pointer 1.
REQ-024 Reset during WRITE or ACK SHALL abort the transaction: no ack pulse, and o_q cleared to zero.
REQ-025 Requests SHALL be ignored in any cycle where i_rst_n is low.

Configuration
REQ-026 Macro REG_ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests, the requester that did not win last SHALL win; the pointer updates only on completed (acked) transactions.
REQ-027 Macro undefined: requester 0 SHALL always win simultaneous requests; the pointer logic SHALL be absent.

Structure
REQ-028 Package reg_arbiter_pkg SHALL hold the state enum typedef, NUM_REQ = 2 and DEFAULT_WIDTH = 8.
REQ-029 Storage SHALL be a sub-module shared_reg (WIDTH-bit register with load enable and synchronous clear, outputs q/qn); arbitration and FSM stay in reg_arbiter.

Verification (WIDTH = 8)
REQ-030 Reset: i_rst_n=0 for 2 cycles -> o_q=8'h00, o_qn=8'hFF, o_gnt=0, o_ack=0, o_busy=0.
REQ-031 Single request: i_req=2'b01, i_d0=8'hA5 -> o_gnt=2'b01 after edge 1; o_q=8'hA5, o_qn=8'h5A, o_ack=2'b01 after edge 2; all cleared after edge 3.
REQ-032 Simultaneous requests held, i_d0=8'h11, i_d1=8'h22 -> round-robin: 8'h11 then 8'h22, alternating acks 01,10; without macro: repeated acks to 01 only, o_q=8'h11.
REQ-033 Abort: i_req=2'b10, then dropped to 0 in WRITE -> no o_ack; o_q keeps its previous value; o_busy low after the next edge.
REQ-034 Reset mid-WRITE with i_d1=8'h3C -> o_q=8'h00, no ack, state IDLE.
REQ-035 Late request: i_req[1] rises while requester 0 is in ACK -> requester 1 granted only after an IDLE cycle; o_gnt never 2'b11.

Source files
------------

// File: rtl/reg_arbiter_pkg.sv
// Shared types and constants for the two-requester register arbiter.
// Holds the FSM state enum, requester count and grant pick helpers.
package reg_arbiter_pkg;

  localparam int NUM_REQ       = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Requester 0 always beats requester 1.
  function automatic logic [NUM_REQ-1:0] pick_fixed(
    input logic [NUM_REQ-1:0] req
  );
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (req[0])      g = 2'b01;
    else if (req[1]) g = 2'b10;
    return g;
  endfunction

  // On a tie the requester that did not win last time goes first.
  // last = index of the previous winner.
  function automatic logic [NUM_REQ-1:0] pick_rr(
    input logic [NUM_REQ-1:0] req,
    input logic               last
  );
    logic [NUM_REQ-1:0] g;
    g = req;
    if (req == 2'b11) g = last ? 2'b01 : 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/reg_arbiter_shared_reg.sv
// shared_reg: WIDTH-bit storage register, load enable, sync clear.
// Ports: i_clk, i_clr (sync clear), i_load, i_d -> o_q, o_qn (= ~o_q).
module shared_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn
);

  logic [WIDTH-1:0] r_q;

  // Clear dominates load.
  always_ff @(posedge i_clk) begin
    if (i_clr)       r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q  = r_q;
  // Combinational inverse so it tracks o_q in every cycle.
  assign o_qn = ~r_q;

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: two requesters share one register via IDLE/WRITE/ACK FSM.
// Ports: i_clk, i_rst_n (sync, active-low), i_req[1:0], i_d0, i_d1,
//        o_gnt[1:0], o_ack[1:0], o_q, o_qn, o_busy.
// Macro REG_ARBITER_ROUND_ROBIN_EN: tie goes to the previous loser;
// undefined: requester 0 wins every tie.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [WIDTH-1:0]   i_d0,
  input  logic [WIDTH-1:0]   i_d1,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [WIDTH-1:0]   o_q,
  output logic [WIDTH-1:0]   o_qn,
  output logic               o_busy
);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_hold;
  logic               w_load;
  logic [WIDTH-1:0]   w_d;

`ifdef REG_ARBITER_ROUND_ROBIN_EN
  // Index of the last requester whose write completed.
  logic r_last;
  assign w_pick = pick_rr(i_req, r_last);
`else
  assign w_pick = pick_fixed(i_req);
`endif

  // Granted requester still asking at the WRITE edge.
  assign w_hold = |(i_req & r_gnt);
  assign w_load = i_rst_n && (r_state == ST_WRITE) && w_hold;
  assign w_d    = r_gnt[1] ? i_d1 : i_d0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (|i_req) begin
            r_state <= ST_WRITE;
            r_gnt   <= w_pick;
            r_busy  <= 1'b1;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (w_hold) begin
            r_state <= ST_ACK;
            r_ack   <= r_gnt;
            r_busy  <= 1'b1;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
            r_last  <= r_gnt[1];
`endif
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  shared_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .i_clk  (i_clk),
    .i_clr  (~i_rst_n),
    .i_load (w_load),
    .i_d    (w_d),
    .o_q    (o_q),
    .o_qn   (o_qn)
  );

  assign o_gnt  = r_gnt;
  assign o_ack  = r_ack;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter, WIDTH = 8.
// Honours REG_ARBITER_ROUND_ROBIN_EN for tie expectations.
module tb_reg_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] q;
  logic [7:0] qn;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit seen_11  = 1'b0;

  reg_arbiter #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_d0    (d0),
    .i_d1    (d1),
    .o_gnt   (gnt),
    .o_ack   (ack),
    .o_q     (q),
    .o_qn    (qn),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (gnt === 2'b11) seen_11 = 1'b1;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] eg,
                         input logic [1:0] ea,
                         input logic       eb,
                         input logic [7:0] eq);
    chk({tag, ".gnt"},  {6'd0, gnt}, {6'd0, eg});
    chk({tag, ".ack"},  {6'd0, ack}, {6'd0, ea});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, ".q"},    q, eq);
    chk({tag, ".qn"},   qn, ~eq);
  endtask

  logic [1:0] e_g2;
  logic [7:0] e_q2;

  initial begin
`ifdef REG_ARBITER_ROUND_ROBIN_EN
    e_g2 = 2'b10;
    e_q2 = 8'h22;
`else
    e_g2 = 2'b01;
    e_q2 = 8'h11;
`endif
    rst_n = 1'b0;
    req   = 2'b00;
    d0    = 8'h00;
    d1    = 8'h00;

    // Reset, with requests asserted in the second cycle
    tick();
    req = 2'b11;
    tick();
    chk_all("reset", 2'b00, 2'b00, 1'b0, 8'h00);
    rst_n = 1'b1;
    req   = 2'b00;
    tick();
    chk_all("idle", 2'b00, 2'b00, 1'b0, 8'h00);

    // Single request from requester 0
    req = 2'b01;
    d0  = 8'hA5;
    tick();
    chk_all("single.e1", 2'b01, 2'b00, 1'b1, 8'h00);
    tick();
    chk_all("single.e2", 2'b01, 2'b01, 1'b1, 8'hA5);
    req = 2'b00;
    tick();
    chk_all("single.e3", 2'b00, 2'b00, 1'b0, 8'hA5);

    // Reset pulse to restart the pointer and clear q
    rst_n = 1'b0;
    tick();
    chk_all("rst2", 2'b00, 2'b00, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Simultaneous requests held for two transactions
    d0  = 8'h11;
    d1  = 8'h22;
    req = 2'b11;
    tick();
    chk_all("sim.e1", 2'b01, 2'b00, 1'b1, 8'h00);
    tick();
    chk_all("sim.e2", 2'b01, 2'b01, 1'b1, 8'h11);
    tick();
    chk_all("sim.e3", 2'b00, 2'b00, 1'b0, 8'h11);
    tick();
    chk_all("sim.e4", e_g2, 2'b00, 1'b1, 8'h11);
    tick();
    chk_all("sim.e5", e_g2, e_g2, 1'b1, e_q2);
    req = 2'b00;
    tick();
    chk_all("sim.e6", 2'b00, 2'b00, 1'b0, e_q2);

    // Abort: request dropped during WRITE
    req = 2'b10;
    d1  = 8'h77;
    tick();
    chk_all("abort.e1", 2'b10, 2'b00, 1'b1, e_q2);
    req = 2'b00;
    tick();
    chk_all("abort.e2", 2'b00, 2'b00, 1'b0, e_q2);

    // Reset in WRITE with request still high
    req = 2'b10;
    d1  = 8'h3C;
    tick();
    chk_all("rstw.e1", 2'b10, 2'b00, 1'b1, e_q2);
    rst_n = 1'b0;
    tick();
    chk_all("rstw.e2", 2'b00, 2'b00, 1'b0, 8'h00);
    rst_n = 1'b1;
    req   = 2'b00;
    tick();
    chk_all("rstw.e3", 2'b00, 2'b00, 1'b0, 8'h00);

    // Late request from 1 while 0 is in ACK; data changes in ACK
    req = 2'b01;
    d0  = 8'h55;
    d1  = 8'h66;
    tick();
    chk_all("late.e1", 2'b01, 2'b00, 1'b1, 8'h00);
    tick();
    chk_all("late.e2", 2'b01, 2'b01, 1'b1, 8'h55);
    req = 2'b10;
    d0  = 8'h00;
    tick();
    chk_all("late.e3", 2'b00, 2'b00, 1'b0, 8'h55);
    tick();
    chk_all("late.e4", 2'b10, 2'b00, 1'b1, 8'h55);
    tick();
    chk_all("late.e5", 2'b10, 2'b10, 1'b1, 8'h66);
    req = 2'b00;
    tick();
    chk_all("late.e6", 2'b00, 2'b00, 1'b0, 8'h66);

    chk("never_gnt_11", {7'd0, seen_11}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
